uart_rx_fifo_param: RTL

// - Parametrised UART receiver: oversampled serial RX front end plus a first-word-fall-through receive FIFO.
// - Successor to the fixed 8N1 receive half of the UART: configurable data width, bit period and FIFO depth,

---
 rtl/uart_rx_fifo_param.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_param
//
// Parametrised UART receiver: a 2-FF synchronised, oversampled serial front end
// feeding a first-word-fall-through receive FIFO. The consumer pops with
// rd_uart and sees the oldest byte on out whenever rx_empty is low.
//
// Parameters
//   DATA_BITS     data bits per frame (5..9), LSB first
//   CLKS_PER_BIT  clk cycles per bit (>= 4); mid-bit sample at CLKS_PER_BIT/2
//   FIFO_DEPTH    receive FIFO entries (power of two, >= 2)
//   PARITY_ODD    0 = even, 1 = odd parity (only with UART_PARITY_EN)
//
// Build option
//   UART_PARITY_EN  when defined, a parity bit follows the data bits and is
//                   checked; a mismatch pulses rxErr instead of pushing.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   rxEnabled  in   1 = receiver active, 0 = state machine held in IDLE
//   rx         in   asynchronous serial input, idles high
//   rd_uart    in   pop strobe, ignored while rx_empty=1
//   out        out  FIFO head, valid while rx_empty=0 (0 when empty)
//   rx_empty   out  FIFO empty
//   full       out  FIFO full
//   rxBusy     out  frame in progress
//   rxErr      out  1-cycle pulse on framing or parity error
//   overrun    out  1-cycle pulse when a good frame is dropped (FIFO full)
// -----------------------------------------------------------------------------
module uart_rx_fifo_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEnabled,
  input  logic                 rx,
  input  logic                 rd_uart,
  output logic [DATA_BITS-1:0] out,
  output logic                 rx_empty,
  output logic                 full,
  output logic                 rxBusy,
  output logic                 rxErr,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Resets to the idle line level so a reset never looks
  // like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_req;
  logic                 stop_ok;

`ifdef UART_PARITY_EN
  logic par_err;
  assign stop_ok = rxs && !par_err;
`else
  assign stop_ok = rxs;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      push_req <= 1'b0;
      rxErr    <= 1'b0;
`ifdef UART_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      // Pulses default low and are raised for exactly one cycle below.
      push_req <= 1'b0;
      rxErr    <= 1'b0;

      if (!rxEnabled) begin
        // Disabling mid-frame silently drops the partial frame.
        state <= S_IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!rxs) begin
              state <= S_START;
              cnt   <= '0;
            end
          end

          // Re-check the line at the middle of the start bit; a line that has
          // already returned high was a glitch and is ignored without error.
          S_START: begin
            if (cnt == CNT_HALF) begin
              cnt   <= '0;
              idx   <= '0;
              state <= rxs ? S_IDLE : S_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          // Counter is now phase-aligned to mid-bit: each wrap is a sample.
          S_DATA: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              idx   <= idx + 1'b1;
              if (idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

`ifdef UART_PARITY_EN
          // XOR of data and parity bit is 0 for even parity, 1 for odd.
          S_PARITY: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              par_err <= ((^shreg) ^ rxs) != (PARITY_ODD != 0);
              state   <= S_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif

          S_STOP: begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (stop_ok) begin
                push_req <= 1'b1;
                state    <= S_IDLE;
              end else begin
                rxErr <= 1'b1;
                state <= S_WAIT_IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          // A line stuck low after a bad frame must not retrigger START.
          S_WAIT_IDLE: begin
            if (rxs) state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rxBusy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Receive FIFO. Pointers carry one extra wrap bit so full and empty can be
  // told apart when the index bits match.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic                 do_pop;
  logic                 do_push;

  assign rx_empty = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop while full frees the slot the simultaneous push needs.
  assign do_pop  = rd_uart && !rx_empty;
  assign do_push = push_req && (!full || do_pop);

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, and out is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      overrun <= push_req && full && !do_pop;
    end
  end

  assign out = rx_empty ? '0 : mem[rptr[AW-1:0]];

endmodule
